// File: rtl/rv32i_types.sv
// Shared RV32I/OoO core types: physical register width, multiply funct3 codes,
// reservation-station entry and common-data-bus broadcast formats.
package rv32i_types;

    localparam int PR_W  = 6;
    localparam int ROB_W = 4;

    localparam logic [2:0] mult_div_op_mul    = 3'b000;
    localparam logic [2:0] mult_div_op_mulh   = 3'b001;
    localparam logic [2:0] mult_div_op_mulhsu = 3'b010;
    localparam logic [2:0] mult_div_op_mulhu  = 3'b011;

    typedef struct packed {
        logic [2:0]       funct3;
        logic [ROB_W-1:0] rob_id;
        logic [4:0]       rd_addr;
        logic [PR_W-1:0]  pd_addr;
        logic [PR_W-1:0]  ps1_addr;
        logic [PR_W-1:0]  ps2_addr;
        logic             ps1_ready;
        logic             ps2_ready;
    } rs_entry_t;

    typedef struct packed {
        logic            ready;
        logic [PR_W-1:0] pr_dest;
    } cdb_t;

    // Physical register 0 is hardwired and therefore always available.
    function automatic logic pr_is_zero(input logic [PR_W-1:0] addr);
        return (addr == {PR_W{1'b0}});
    endfunction

endpackage

// File: rtl/mul_rs_wakeup.sv
// Source-operand wakeup: marks ps1/ps2 ready when any CDB port broadcasts
// the matching physical tag. Pure combinational, one instance per slot.
module mul_rs_wakeup
    import rv32i_types::*;
#(
    parameter int CDB_PORTS = 2
) (
    input  rs_entry_t entry_in,
    input  cdb_t      cdb [CDB_PORTS],
    output rs_entry_t entry_out
);

    logic hit1_s;
    logic hit2_s;

    // Tag match against every broadcast port, OR-reduced per source.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            hit1_s = hit1_s | (cdb[p].ready & (cdb[p].pr_dest == entry_in.ps1_addr));
            hit2_s = hit2_s | (cdb[p].ready & (cdb[p].pr_dest == entry_in.ps2_addr));
        end
        entry_out           = entry_in;
        entry_out.ps1_ready = entry_in.ps1_ready | hit1_s;
        entry_out.ps2_ready = entry_in.ps2_ready | hit2_s;
    end

endmodule

// File: rtl/mul_rs.sv
// Multiply reservation station: collapsing age-ordered queue with CDB wakeup,
// oldest-ready select and issue handshake towards the multiply ALU.
module mul_rs
    import rv32i_types::*;
#(
    parameter int DEPTH     = 4,
    parameter int CDB_PORTS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            dispatch_valid,
    input  rs_entry_t       dispatch_entry,
    output logic            dispatch_ready,
    input  cdb_t            cdb [CDB_PORTS],
    output logic            rs_entry_valid,
    output rs_entry_t       rs_entry_dout,
    input  logic            alu_ready,
    output logic [PR_W-1:0] ps1_addr,
    output logic [PR_W-1:0] ps2_addr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH);

    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic [CW-1:0]    ins_idx_s;
    logic [SW-1:0]    sel_idx_s;
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] valid_next_s;
    logic [DEPTH-1:0] valid_shift_s;
    logic [DEPTH-1:0] rdy_vec_s;
    logic             dispatch_ready_r;
    logic             sel_found_s;
    logic             issue_s;
    logic             dispatch_fire_s;
    rs_entry_t        entry_r      [DEPTH];
    rs_entry_t        entry_next_s [DEPTH];
    rs_entry_t        woken_s      [DEPTH+1];
    rs_entry_t        disp_in_s;

    // Index DEPTH of woken_s is the dispatch path (snoop-on-insert).
    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        mul_rs_wakeup #(.CDB_PORTS(CDB_PORTS)) u_wake (
            .entry_in  (entry_r[g]),
            .cdb       (cdb),
            .entry_out (woken_s[g])
        );
    end

    mul_rs_wakeup #(.CDB_PORTS(CDB_PORTS)) u_wake_disp (
        .entry_in  (disp_in_s),
        .cdb       (cdb),
        .entry_out (woken_s[DEPTH])
    );

    // Incoming op: sources naming p0 are ready regardless of rename's bits.
    always_comb begin
        disp_in_s           = dispatch_entry;
        disp_in_s.ps1_ready = dispatch_entry.ps1_ready | pr_is_zero(dispatch_entry.ps1_addr);
        disp_in_s.ps2_ready = dispatch_entry.ps2_ready | pr_is_zero(dispatch_entry.ps2_addr);
    end

    // Oldest-first priority encoder over registered ready bits only.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {SW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec_s[i] = valid_r[i] & entry_r[i].ps1_ready & entry_r[i].ps2_ready;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy_vec_s[i]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = SW'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    assign issue_s         = sel_found_s & alu_ready;
    assign dispatch_fire_s = dispatch_valid & dispatch_ready_r;
    assign ins_idx_s       = issue_s ? (count_r - CW'(1)) : count_r;
    assign count_next_s    = count_r - CW'(issue_s) + CW'(dispatch_fire_s);
    assign valid_shift_s   = {1'b0, valid_r[DEPTH-1:1]};

    // Compose wakeup, collapse above the issued slot, and insert at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_s && (SW'(i) >= sel_idx_s)) begin
                entry_next_s[i] = woken_s[i+1];
                valid_next_s[i] = valid_shift_s[i];
            end else begin
                entry_next_s[i] = woken_s[i];
                valid_next_s[i] = valid_r[i];
            end
            if (dispatch_fire_s && (CW'(i) == ins_idx_s)) begin
                entry_next_s[i] = woken_s[DEPTH];
                valid_next_s[i] = 1'b1;
            end else begin
                valid_next_s[i] = valid_next_s[i];
            end
        end
    end

    // Occupancy state; flush behaves like reset for bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_r          <= {CW{1'b0}};
            valid_r          <= {DEPTH{1'b0}};
            dispatch_ready_r <= 1'b1;
        end else begin
            count_r          <= count_next_s;
            valid_r          <= valid_next_s;
            dispatch_ready_r <= (count_next_s < CW'(DEPTH));
        end
    end

    // Entry payload needs no reset: it is qualified by valid_r.
    always_ff @(posedge clk) begin
        entry_r <= entry_next_s;
    end

    assign dispatch_ready = dispatch_ready_r;
    assign rs_entry_valid = issue_s;
    assign rs_entry_dout  = entry_r[sel_idx_s];
    assign ps1_addr       = entry_r[sel_idx_s].ps1_addr;
    assign ps2_addr       = entry_r[sel_idx_s].ps2_addr;

endmodule

// File: doc/mul_rs.md
# mul_rs

Reservation station for the multiply functional unit, directly upstream of the multiply ALU. Buffers dispatched multiply ops (mul/mulh/mulhsu/mulhu), snoops the common data buses to mark physical source operands ready, and issues the oldest ready entry when the ALU asserts ready. Issue also drives the physical-regfile read addresses in the same cycle.

## Interface
Parameters:
- DEPTH, 4, number of entries (≥2).
- CDB_PORTS, 2, number of CDB broadcast ports snooped for wakeup.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- flush  in  1  mispredict flush; invalidates all entries.
- dispatch_valid  in  1  rename/dispatch presents an op.
- dispatch_entry  in  rs_entry_t  op. Fields used: funct3, rob_id, rd_addr, pd_addr, ps1_addr, ps2_addr, ps1_ready, ps2_ready.
- dispatch_ready  out  1  station can accept (count < DEPTH).
- cdb  in  cdb_t[CDB_PORTS]  broadcasts. Fields used: ready (valid), pr_dest (tag).
- rs_entry_valid  out  1  issue strobe to the ALU.
- rs_entry_dout  out  rs_entry_t  issued entry.
- alu_ready  in  1  ALU accepting (its ready output).
- ps1_addr, ps2_addr  out  PR width  regfile read addresses of the selected entry; combinational.

## Operation
- Storage is a collapsing age-ordered queue: slot 0 is oldest, valid slots contiguous from 0, count register 0..DEPTH.
- Dispatch fires when dispatch_valid & dispatch_ready. The entry is written at slot count, or at count-1 if an issue fires in the same cycle.
- Wakeup: for each valid entry and source, set ready if any cdb[i].ready with pr_dest == that source addr. Also applied to the dispatching entry in its insert cycle (snoop-on-insert), so a same-cycle broadcast is never missed.
- Physical register 0: a source with addr 0 is ready on insert regardless of dispatch bits.
- Select: the lowest-index valid entry with ps1_ready & ps2_ready.
- Issue fires when a selected entry exists & alu_ready; rs_entry_valid = issue.
  - rs_entry_dout and ps1/ps2_addr reflect the selected entry whenever any is ready, else don't-care.
- On issue, the entry is removed at the clock edge. Slots above it shift down one; count decrements unless a dispatch fires the same cycle.
- Wakeup, shift and insert compose in one edge: a shifted entry keeps its own (and newly woken) ready bits.
- flush: the next edge clears count and all valid bits and takes priority over dispatch, wakeup and issue. An issue presented in the flush cycle still reaches the ALU; discarding it is the ROB's job.
- dispatch_ready is purely registered-state based (count < DEPTH). A full station with a same-cycle issue still rejects dispatch.

## Timing
- Reset: count=0, all entries invalid; dispatch_ready=1, rs_entry_valid=0.
- Dispatch accepted at edge N with sources ready → earliest issue in cycle N+1 (combinational select from registers).
- CDB broadcast of a tag in cycle N → the dependent entry can issue in cycle N+1, not N.
- Throughput: one issue per cycle limit from the station; the real rate is gated by alu_ready.
- Reset or flush mid-operation: both take effect at the next edge. No partial entries survive.

## Structure
- rs_entry_t, cdb_t, the PR address width and the mult_div_op_* funct3 constants live in rv32i_types; this block adds no new package types.
- A natural sub-module is mul_rs_wakeup: per-entry comparison of the source tags against all CDB ports, returning the new ready bits. It is instantiated DEPTH+1 times (each slot plus the dispatch path).
- Select is a priority encoder over ready & valid.

## Test plan
- Reset, then dispatch mul with ps1=5 ready and ps2=6 ready, alu_ready=1 → rs_entry_valid=1 next cycle with ps1_addr=5 and ps2_addr=6; count returns to 0.
- Dispatch A (ps1=7 not ready) then B (all ready) → B issues first; broadcast cdb[1] pr_dest=7 in cycle N → A issues in cycle N+1.
- Fill 4 entries with none ready → dispatch_ready=0, and a 5th dispatch is dropped. Broadcasts wake entries in order 2,0 → issue order slot 0 (oldest), then the former slot 2, with slots shifting correctly.
- Dispatch with ps2=9 in the same cycle cdb[0] broadcasts pr_dest=9 → entry is inserted ready and issues the next cycle.
- alu_ready=0 for 5 cycles with 2 ready entries → no issue and entries held. When alu_ready rises, one issue per cycle, oldest first.
- 3 valid entries with flush asserted together with a dispatch → next cycle count=0 and dispatch_ready=1; no issue follows.
